// File: rtl/axis_tx_arb_pkg.sv
// Shared types and constants for the AXIS transmit arbiter.
// Holds the beat layout, FSM states and soft-register bundles.
package axis_tx_arb_pkg;

  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_DEST_W = 5;
  localparam int BEAT_W      = AXIS_DATA_W + AXIS_DEST_W + 1;

  localparam logic [31:0] CFG_BASE = 32'h000;
  localparam logic [31:0] CNT_BASE = 32'h100;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

  function automatic logic [BEAT_W-1:0] pack_beat(
    input logic [AXIS_DATA_W-1:0] d,
    input logic [AXIS_DEST_W-1:0] dst,
    input logic                   lst
  );
    return {d, dst, lst};
  endfunction

endpackage

// File: rtl/axis_tx_arb_if.sv
// Valid/ready stream bundle with a flat payload.
// Used between the arbiter core and its output slice.
interface axis_tx_arb_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/axis_reg_slice.sv
// Two-entry in-order output slice; accepts while not full.
// Output payload comes straight from a register, so it holds while stalled.
module axis_reg_slice
  import axis_tx_arb_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic           clk,
  input  logic           rst,
  axis_tx_arb_if.slave   s_if,
  axis_tx_arb_if.master  m_if
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push, pop;

  assign s_if.ready = (cnt_q != 2'd2);
  assign m_if.valid = (cnt_q != 2'd0);
  assign m_if.data  = mem_q[rd_q];

  assign push = s_if.valid && s_if.ready;
  assign pop  = m_if.valid && m_if.ready;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = s_if.data;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_tx_arb.sv
// Round-robin merge of N app streams into one tagged stream.
// Grants run until packet end or MAX_BURST beats; one idle cycle between.
module axis_tx_arb
  import axis_tx_arb_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  SoftRegReq                      softreg_req,
  output SoftRegResp                     softreg_resp,
  input  logic [N_PORTS-1:0]             in_tvalid,
  output logic [N_PORTS-1:0]             in_tready,
  input  logic [N_PORTS-1:0]             in_tlast,
  input  logic [AXIS_DATA_W*N_PORTS-1:0] in_tdata,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic [AXIS_DATA_W-1:0]         out_tdata,
  output logic [AXIS_DEST_W-1:0]         out_tdest,
  output logic                           out_tlast
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int CNT_W = 7;

  arb_state_e                            state_q, state_d;
  logic [IDX_W-1:0]                      g_q, g_d;
  logic [IDX_W-1:0]                      rr_q, rr_d;
  logic [AXIS_DEST_W-1:0]                dest_q, dest_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [N_PORTS-1:0]                    cfg_en_q, cfg_en_d;
  logic [N_PORTS-1:0][AXIS_DEST_W-1:0]   cfg_dest_q, cfg_dest_d;
  logic [N_PORTS-1:0][31:0]              beat_cnt_q, beat_cnt_d;
  SoftRegResp                            resp_q, resp_d;

  logic                   grant_ok;
  logic [IDX_W-1:0]       grant_idx;
  logic                   accept;
  logic                   sel_valid;
  logic                   sel_last;
  logic [AXIS_DATA_W-1:0] sel_data;
  logic [IDX_W-1:0]       g_next;
  logic                   sr_unused;

  axis_tx_arb_if #(.W(BEAT_W)) push_if ();
  axis_tx_arb_if #(.W(BEAT_W)) pop_if ();

  axis_reg_slice #(.W(BEAT_W)) u_slice (
    .clk  (clk),
    .rst  (rst),
    .s_if (push_if.slave),
    .m_if (pop_if.master)
  );

  assign pop_if.ready = out_tready;
  assign out_tvalid   = pop_if.valid;
  assign {out_tdata, out_tdest, out_tlast} = pop_if.data;
  assign softreg_resp = resp_q;
  assign sr_unused    = ^{softreg_req.data[63:9], softreg_req.data[7:5]};

  assign sel_valid = in_tvalid[g_q];
  assign sel_last  = in_tlast[g_q];
  assign sel_data  = in_tdata[AXIS_DATA_W*g_q +: AXIS_DATA_W];
  assign g_next    = (g_q == IDX_W'(N_PORTS - 1)) ? '0 : g_q + IDX_W'(1);

  // First eligible port scanning cyclically from the round-robin pointer
  always_comb begin
    int idx;
    idx       = 0;
    grant_ok  = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = (int'(rr_q) + k) % N_PORTS;
      if (!grant_ok && in_tvalid[idx] && cfg_en_q[idx]) begin
        grant_ok  = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    rr_d         = rr_q;
    dest_d       = dest_q;
    cnt_d        = cnt_q;
    in_tready    = '0;
    accept       = 1'b0;
    push_if.valid = 1'b0;
    push_if.data  = pack_beat(sel_data, dest_q, sel_last);
    unique case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          g_d     = grant_idx;
          dest_d  = cfg_dest_q[grant_idx];
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        in_tready[g_q] = push_if.ready;
        accept         = sel_valid && push_if.ready;
        push_if.valid  = accept;
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (sel_last || cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = ST_IDLE;
            rr_d    = g_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      beat_cnt_d[g_q] = beat_cnt_q[g_q] + 32'd1;
    end
  end

  // Register file: config writes and one-cycle read responses
  always_comb begin
    cfg_en_d   = cfg_en_q;
    cfg_dest_d = cfg_dest_q;
    resp_d     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (softreg_req.valid && softreg_req.isWrite &&
          softreg_req.addr == CFG_BASE + 32'(8 * i)) begin
        cfg_dest_d[i] = softreg_req.data[AXIS_DEST_W-1:0];
        cfg_en_d[i]   = softreg_req.data[8];
      end
    end
    if (softreg_req.valid && !softreg_req.isWrite) begin
      resp_d.valid = 1'b1;
      for (int i = 0; i < N_PORTS; i++) begin
        if (softreg_req.addr == CFG_BASE + 32'(8 * i)) begin
          resp_d.data = {55'd0, cfg_en_q[i], 3'd0, cfg_dest_q[i]};
        end
        if (softreg_req.addr == CNT_BASE + 32'(8 * i)) begin
          resp_d.data = {32'd0, beat_cnt_q[i]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      g_q        <= '0;
      rr_q       <= '0;
      dest_q     <= '0;
      cnt_q      <= '0;
      cfg_en_q   <= '0;
      cfg_dest_q <= '0;
      beat_cnt_q <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      dest_q     <= dest_d;
      cnt_q      <= cnt_d;
      cfg_en_q   <= cfg_en_d;
      cfg_dest_q <= cfg_dest_d;
      beat_cnt_q <= beat_cnt_d;
      resp_q     <= resp_d;
    end
  end

endmodule

// File: doc/axis_tx_arb.md
AXIS_TX_ARB -- requirements
Module: axis_tx_arb

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of app-side input streams (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 64, maximum beats per grant (power of two, at most 64).
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port softreg_req, input, SoftRegReq, configuration and status access.
REQ-006 SHALL have port softreg_resp, output, SoftRegResp, read response.
REQ-007 SHALL have ports in_tvalid/in_tready/in_tlast, input/output/input, N_PORTS each, per-port handshake and packet end.
REQ-008 SHALL have port in_tdata, input, 512*N_PORTS, per-port data, with port i at bits [512*i+511:512*i].
REQ-009 SHALL have ports out_tvalid/out_tready, output/input, 1 each, merged-stream handshake toward the stream buffer.
REQ-010 SHALL have ports out_tdata/out_tdest/out_tlast, output, 512/5/1, merged beat, its stream number, and its packet end.

Function
REQ-011 SHALL per port hold cfg_en (1b) and cfg_dest (5b); softreg write to addr 0x000+8*i sets cfg_dest[i]=data[4:0] and cfg_en[i]=data[8]; writes to i>=N_PORTS are ignored.
REQ-012 SHALL answer softreg reads with 1-cycle latency: 0x000+8*i returns {cfg_en[i] at bit 8, cfg_dest[i]}; 0x100+8*i returns beat_cnt[i] (32b); any other address returns 0.
REQ-013 SHALL implement FSM IDLE/BURST; a port is eligible when in_tvalid=1 and cfg_en=1.
REQ-014 In IDLE with an eligible port: grant the first eligible index at or after rr_ptr (cyclic), latch g, latch dest=cfg_dest[g], zero cnt, go to BURST next cycle; with no eligible port, stay in IDLE.
REQ-015 In BURST: in_tready[g] = !skid_full; all other in_tready = 0; in IDLE all in_tready = 0.
REQ-016 Accepted beat = in_tvalid[g] && in_tready[g]; it is pushed to the output slice as {in_tdata[g], dest, in_tlast[g]}, cnt increments, and beat_cnt[g] increments with 32-bit wrap.
REQ-017 Burst SHALL terminate on an accepted beat with in_tlast=1 or cnt==MAX_BURST-1; then FSM goes to IDLE and rr_ptr=(g+1) mod N_PORTS.
REQ-018 out_tlast SHALL equal the source in_tlast and never be forced at a MAX_BURST cut.
REQ-019 cfg_en/cfg_dest changes during BURST SHALL NOT affect the current burst; they take effect at the next grant.
REQ-020 Output slice: 2 entries, in order; beat accepted at cycle t is visible on out_tvalid at t+1 when the slice was empty; sustains 1 beat/cycle; skid_full = 2 entries held.
REQ-021 A stalled out_tready SHALL hold out_tdata/out_tdest/out_tlast stable while out_tvalid=1.
REQ-022 Arbitration bubble: exactly 1 idle cycle between bursts (the IDLE cycle).
REQ-023 in_tvalid[g] deasserting mid-burst SHALL keep the grant (no timeout).

Reset
REQ-024 Reset SHALL take effect asynchronously and set the FSM to IDLE, rr_ptr=0, cnt=0, g=0, cfg_en=0, cfg_dest=0, beat_cnt=0, slice empty, out_tvalid=0, all in_tready=0, and softreg_resp.valid=0.
REQ-025 Reset mid-burst SHALL drop slice contents and the partial burst without completion.

Structure
REQ-026 SHALL place AXIS_DATA_W=512, AXIS_DEST_W=5, and the FSM state enum in the shared package.
REQ-027 SHALL implement the output slice as sub-module axis_reg_slice (width parameter, 2 entries).

Verification
REQ-028 Scenario: port0 enabled with dest=3 sends 4 beats, last on beat 4, out_tready=1 -> 4 out beats with tdest=3, tlast only on the 4th, first beat 2 cycles after in_tvalid rises.
REQ-029 Scenario: ports 0 and 2 enabled, each sending 130-beat packets -> grants alternate 0,2,0,2 in 64-beat chunks, then final 2-beat chunks; out_tlast=1 only on beat 130 of each packet.
REQ-030 Scenario: port1 disabled with in_tvalid=1 -> in_tready[1] stays 0 and no beat appears; after writing 0x008 with data 0x105, the next beat carries tdest=5.
REQ-031 Scenario: out_tready=0 for 10 cycles mid-burst -> exactly 2 beats accepted then in_tready=0, output stable; on release, no loss or duplication.
REQ-032 Scenario: cfg_dest[0] rewritten 7->9 during a burst -> remaining beats of the burst carry tdest=7, next burst carries 9; reading 0x100 returns the correct beat count.
REQ-033 Scenario: rst asserted mid-burst -> out_tvalid=0 immediately, all config reads return 0, no further beats until reconfigured.
